// File: rtl/fetch_mem_pkg.sv
// ----------------------------------------------------------------------------
// fetch_mem_pkg
// Shared encodings for the instruction-fetch / data-memory sequencer:
//   - memory command codes driven on mem_cmd
//   - branch mode codes accepted on branch_mode
//   - sequencer state enum
// ----------------------------------------------------------------------------
package fetch_mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        BR_HOLD = 2'b00,
        BR_REL  = 2'b01,
        BR_ABS  = 2'b10
    } br_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STORE
    } state_e;

endpackage

// File: rtl/pc_next_logic.sv
// ----------------------------------------------------------------------------
// pc_next_logic
// Combinational next-PC selection. Priority: reset > increment > branch > hold.
// Ports:
//   reset_i        active-low reset, forces RESET_PC
//   pc_i           current PC
//   inc_i          completed fetch, advance PC by one
//   branch_en_i    branch request qualified by the sequencer being idle
//   branch_mode_i  BR_REL / BR_ABS / BR_HOLD
//   branch_off_i   signed offset for BR_REL
//   branch_tgt_i   absolute target for BR_ABS
//   pc_o           next PC value
// ----------------------------------------------------------------------------
module pc_next_logic
    import fetch_mem_pkg::*;
#(
    parameter int              ADDR_W   = 9,
    parameter int              OFF_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inc_i,
    input  logic              branch_en_i,
    input  logic [1:0]        branch_mode_i,
    input  logic [OFF_W-1:0]  branch_off_i,
    input  logic [ADDR_W-1:0] branch_tgt_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] off_ext;

    // Size cast of a signed operand sign-extends the offset to the PC width.
    assign off_ext = ADDR_W'(signed'(branch_off_i));

    always_comb begin
        // NOTE: default assignment first so every path drives pc_o and no latch is inferred.
        pc_o = pc_i;
        if (!reset_i) begin
            pc_o = RESET_PC;
        end else if (inc_i) begin
            pc_o = pc_i + 1'b1;
        end else if (branch_en_i) begin
            unique case (branch_mode_i)
                BR_REL:  pc_o = pc_i + off_ext;
                BR_ABS:  pc_o = branch_tgt_i;
                default: pc_o = pc_i;
            endcase
        end
    end

endmodule

// File: rtl/fetch_mem_unit.sv
// ----------------------------------------------------------------------------
// fetch_mem_unit
// Instruction-fetch and data-memory sequencer with wait-state handshake.
// Owns the PC, instruction register and data address register.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req_fetch/req_load/req_store access requests (store > load > fetch)
//   data_addr, store_data       data-side address and write data
//   branch_take/mode/off/tgt    PC update, honoured only while idle
//   mem_rdata, mem_ready        memory read data and completion
//   mem_cmd, mem_addr, mem_wdata memory command port
//   instr, instr_valid          instruction register and update pulse
//   load_data, load_valid       last loaded word and update pulse
//   pc                          current PC (link value for BL)
//   busy                        an access is in flight
// ----------------------------------------------------------------------------
module fetch_mem_unit
    import fetch_mem_pkg::*;
#(
    parameter int              ADDR_W   = 9,
    parameter int              DATA_W   = 16,
    parameter int              OFF_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_fetch,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              branch_take,
    input  logic [1:0]        branch_mode,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] load_data_q;
    logic              instr_valid_q;
    logic              load_valid_q;
    logic              fetch_done;
    logic              branch_en;

    assign fetch_done = (state_q == ST_FETCH) && mem_ready;
    assign branch_en  = (state_q == ST_IDLE) && branch_take;

    pc_next_logic #(
        .ADDR_W   (ADDR_W),
        .OFF_W    (OFF_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .reset_i       (reset),
        .pc_i          (pc_q),
        .inc_i         (fetch_done),
        .branch_en_i   (branch_en),
        .branch_mode_i (branch_mode),
        .branch_off_i  (branch_off),
        .branch_tgt_i  (branch_tgt),
        .pc_o          (pc_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        // pc_d already resolves reset, so the PC register loads it unconditionally.
        // A branch in the same idle cycle as a fetch lands here first, so the
        // FETCH state addresses the updated PC.
        pc_q <= pc_d;
        if (!reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            instr_q       <= '0;
            load_data_q   <= '0;
            instr_valid_q <= 1'b0;
            load_valid_q  <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            load_valid_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_store) begin
                        addr_q  <= data_addr;
                        wdata_q <= store_data;
                        state_q <= ST_STORE;
                    end else if (req_load) begin
                        addr_q  <= data_addr;
                        state_q <= ST_LOAD;
                    end else if (req_fetch) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        instr_q       <= mem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (mem_ready) begin
                        load_data_q  <= mem_rdata;
                        load_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_STORE: begin
                    if (mem_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port is decoded from registered state only; holding state during
    // a wait therefore holds command and address stable.
    always_comb begin
        mem_cmd  = MEM_NONE;
        mem_addr = pc_q;
        unique case (state_q)
            ST_FETCH: begin
                mem_cmd  = MEM_READ;
                mem_addr = pc_q;
            end
            ST_LOAD: begin
                mem_cmd  = MEM_READ;
                mem_addr = addr_q;
            end
            ST_STORE: begin
                mem_cmd  = MEM_WRITE;
                mem_addr = addr_q;
            end
            default: begin
                mem_cmd  = MEM_NONE;
                mem_addr = pc_q;
            end
        endcase
    end

    assign mem_wdata   = wdata_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_mem_unit
// Directed bench for fetch_mem_unit with hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_fetch_mem_unit;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int OFF_W  = 8;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] B_HOLD  = 2'b00;
    localparam logic [1:0] B_REL   = 2'b01;
    localparam logic [1:0] B_ABS   = 2'b10;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_fetch, req_load, req_store;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] store_data;
    logic              branch_take;
    logic [1:0]        branch_mode;
    logic [OFF_W-1:0]  branch_off;
    logic [ADDR_W-1:0] branch_tgt;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    fetch_mem_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OFF_W    (OFF_W),
        .RESET_PC ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_fetch   (req_fetch),
        .req_load    (req_load),
        .req_store   (req_store),
        .data_addr   (data_addr),
        .store_data  (store_data),
        .branch_take (branch_take),
        .branch_mode (branch_mode),
        .branch_off  (branch_off),
        .branch_tgt  (branch_tgt),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_cmd     (mem_cmd),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .pc          (pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        req_fetch   = 1'b0;
        req_load    = 1'b0;
        req_store   = 1'b0;
        data_addr   = '0;
        store_data  = '0;
        branch_take = 1'b0;
        branch_mode = B_HOLD;
        branch_off  = '0;
        branch_tgt  = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b1;
        check("rst_pc",          32'(pc),          32'h0);
        check("rst_cmd",         32'(mem_cmd),     32'(C_NONE));
        check("rst_busy",        32'(busy),        32'h0);
        check("rst_instr",       32'(instr),       32'h0);
        check("rst_load_data",   32'(load_data),   32'h0);
        check("rst_wdata",       32'(mem_wdata),   32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_load_valid",  32'(load_valid),  32'h0);

        // Zero-wait fetch
        req_fetch = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hA5C3;
        tick();
        req_fetch = 1'b0;
        check("f0_cmd",  32'(mem_cmd),  32'(C_READ));
        check("f0_addr", 32'(mem_addr), 32'h000);
        check("f0_busy", 32'(busy),     32'h1);
        tick();
        check("f0_instr", 32'(instr),       32'hA5C3);
        check("f0_valid", 32'(instr_valid), 32'h1);
        check("f0_pc",    32'(pc),          32'h001);
        check("f0_idle",  32'(mem_cmd),     32'(C_NONE));
        check("f0_nbusy", 32'(busy),        32'h0);
        tick();
        check("f0_pulse_end", 32'(instr_valid), 32'h0);

        // Fetch with three wait states
        mem_ready = 1'b0;
        mem_rdata = 16'h1111;
        req_fetch = 1'b1;
        tick();
        req_fetch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fw_cmd",   32'(mem_cmd),     32'(C_READ));
            check("fw_addr",  32'(mem_addr),    32'h001);
            check("fw_busy",  32'(busy),        32'h1);
            check("fw_valid", 32'(instr_valid), 32'h0);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        check("fw_instr", 32'(instr),       32'h1111);
        check("fw_pulse", 32'(instr_valid), 32'h1);
        check("fw_pc",    32'(pc),          32'h002);

        // PC wrap: jump to 1FF then fetch
        branch_take = 1'b1;
        branch_mode = B_ABS;
        branch_tgt  = 9'h1FF;
        tick();
        branch_take = 1'b0;
        check("abs_1ff", 32'(pc), 32'h1FF);
        req_fetch = 1'b1;
        mem_rdata = 16'h2222;
        tick();
        req_fetch = 1'b0;
        check("wrap_addr", 32'(mem_addr), 32'h1FF);
        tick();
        check("wrap_pc", 32'(pc), 32'h000);

        // Relative branch backwards by 2 from 5
        branch_take = 1'b1;
        branch_mode = B_ABS;
        branch_tgt  = 9'h005;
        tick();
        check("abs_5", 32'(pc), 32'h005);
        branch_mode = B_REL;
        branch_off  = 8'hFE;
        tick();
        check("rel_m2", 32'(pc), 32'h003);
        branch_mode = B_HOLD;
        tick();
        check("hold", 32'(pc), 32'h003);
        branch_mode = B_ABS;
        branch_tgt  = 9'h040;
        tick();
        check("abs_40", 32'(pc), 32'h040);

        // Branch and fetch together; branch ignored while busy
        branch_tgt = 9'h077;
        req_fetch  = 1'b1;
        mem_ready  = 1'b0;
        tick();
        req_fetch  = 1'b0;
        branch_tgt = 9'h100;
        check("bf_addr", 32'(mem_addr), 32'h077);
        check("bf_pc",   32'(pc),       32'h077);
        tick();
        check("busy_br_ignored", 32'(pc), 32'h077);
        branch_take = 1'b0;
        mem_ready   = 1'b1;
        mem_rdata   = 16'h4444;
        tick();
        check("bf_pc_inc", 32'(pc), 32'h078);

        // Store wins over fetch; fetch accepted after return to idle
        req_store  = 1'b1;
        req_fetch  = 1'b1;
        data_addr  = 9'h012;
        store_data = 16'h1234;
        tick();
        req_store = 1'b0;
        check("st_cmd",   32'(mem_cmd),   32'(C_WRITE));
        check("st_addr",  32'(mem_addr),  32'h012);
        check("st_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        check("st_done_cmd",  32'(mem_cmd),     32'(C_NONE));
        check("st_no_ivalid", 32'(instr_valid), 32'h0);
        mem_rdata = 16'h3333;
        tick();
        req_fetch = 1'b0;
        check("st_fetch_cmd",  32'(mem_cmd),  32'(C_READ));
        check("st_fetch_addr", 32'(mem_addr), 32'h078);
        tick();
        check("st_fetch_instr", 32'(instr), 32'h3333);
        check("st_fetch_pc",    32'(pc),    32'h079);

        // Load from 0FF
        req_load  = 1'b1;
        data_addr = 9'h0FF;
        mem_rdata = 16'hBEEF;
        tick();
        req_load = 1'b0;
        check("ld_cmd",  32'(mem_cmd),  32'(C_READ));
        check("ld_addr", 32'(mem_addr), 32'h0FF);
        tick();
        check("ld_data",   32'(load_data),   32'hBEEF);
        check("ld_valid",  32'(load_valid),  32'h1);
        check("ld_instr",  32'(instr),       32'h3333);
        check("ld_pc",     32'(pc),          32'h079);
        check("ld_nivld",  32'(instr_valid), 32'h0);
        tick();
        check("ld_pulse_end", 32'(load_valid), 32'h0);

        // Reset in the middle of a load wait
        mem_ready = 1'b0;
        req_load  = 1'b1;
        data_addr = 9'h0AB;
        tick();
        req_load = 1'b0;
        check("lr_cmd",  32'(mem_cmd),  32'(C_READ));
        check("lr_addr", 32'(mem_addr), 32'h0AB);
        tick();
        reset = 1'b0;
        tick();
        check("lr_cmd_none", 32'(mem_cmd),    32'(C_NONE));
        check("lr_busy",     32'(busy),       32'h0);
        check("lr_pc",       32'(pc),         32'h000);
        check("lr_lvalid",   32'(load_valid), 32'h0);
        check("lr_ldata",    32'(load_data),  32'h0);
        check("lr_wdata",    32'(mem_wdata),  32'h0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("lr_after_lvalid", 32'(load_valid), 32'h0);
        check("lr_after_busy",   32'(busy),       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
# fetch_mem_unit

Parametrised instruction-fetch and data-memory sequencer for the RISC core. It owns the program counter, instruction register and data address register, and adds three things the current PC/address logic lacks: configurable widths, a wait-state memory handshake (`mem_ready`), and PC-relative, absolute and link branching. It sits between the FSM controller/datapath and the memory port, and replaces the inline PC, instruction-register and address-mux logic in the CPU top level.

## Interface
Parameters:
- ADDR_W, 9, width of PC, data address and `mem_addr`
- DATA_W, 16, width of instruction and data words
- OFF_W, 8, width of the signed branch offset
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_fetch  in  1  request an instruction fetch at `pc`
- req_load  in  1  request a data read at `data_addr`
- req_store  in  1  request a data write of `store_data` to `data_addr`
- data_addr  in  ADDR_W  data address from the datapath
- store_data  in  DATA_W  write data from the datapath
- branch_take  in  1  apply a PC update this cycle
- branch_mode  in  2  BR_REL, BR_ABS, BR_HOLD (see package)
- branch_off  in  OFF_W  signed offset, used with BR_REL
- branch_tgt  in  ADDR_W  absolute target, used with BR_ABS
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory has completed the current command
- mem_cmd  out  2  MEM_NONE, MEM_READ or MEM_WRITE
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- instr  out  DATA_W  instruction register
- instr_valid  out  1  one-cycle pulse: `instr` has been updated
- load_data  out  DATA_W  last loaded data word
- load_valid  out  1  one-cycle pulse: `load_data` has been updated
- pc  out  ADDR_W  current PC; also serves as the link value for BL
- busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, FETCH, LOAD, STORE.
- Request acceptance:
  - A request is accepted only in IDLE.
  - If several requests are high together, priority is store > load > fetch; the losers are ignored and must be held by the controller.
- On accepting a load or store:
  - `data_addr` is latched into the address register.
  - For a store, `store_data` is also latched into `mem_wdata`.
- FETCH:
  - `mem_cmd` = MEM_READ and `mem_addr` = `pc`.
  - When `mem_ready` is high: `instr` ← `mem_rdata`, `pc` ← `pc`+1 (wraps modulo 2^ADDR_W), `instr_valid` pulses, state returns to IDLE.
- LOAD:
  - `mem_cmd` = MEM_READ and `mem_addr` = address register.
  - When `mem_ready` is high: `load_data` ← `mem_rdata`, `load_valid` pulses, state returns to IDLE.
- STORE:
  - `mem_cmd` = MEM_WRITE and `mem_addr` = address register.
  - When `mem_ready` is high, state returns to IDLE.
- In IDLE: `mem_cmd` = MEM_NONE and `mem_addr` = `pc`.
- Wait states: `mem_ready` low keeps the state, `mem_cmd`, `mem_addr` and `mem_wdata` all stable. The wait is unbounded.
- Branching (sampled only in IDLE; ignored while `busy`=1):
  - BR_REL: `pc` ← `pc` + sign-extended `branch_off`, modulo 2^ADDR_W. `pc` has already been incremented past the branch instruction.
  - BR_ABS: `pc` ← `branch_tgt`.
  - BR_HOLD: no change.
- Branch plus fetch in the same IDLE cycle: the PC update happens first, and the fetch then uses the new `pc`.
- Reset (reset=0 at an edge) is effective from any state, including mid-access. Values after reset:
  - state IDLE, `pc`=RESET_PC
  - `instr`, `load_data`, `mem_wdata` and the address register = 0
  - `instr_valid`, `load_valid` and `busy` = 0, `mem_cmd` = MEM_NONE

## Timing
- Request sampled at edge E0 → `mem_cmd` is valid in the cycle after E0.
- `mem_ready` sampled high at edge E1 → `instr`/`load_data` are updated at E1, and the valid pulse is high for exactly the cycle after E1.
- Zero-wait memory: request-to-valid takes 2 edges. Each wait cycle adds 1.
- `busy` is high from after E0 up to E1. The earliest next acceptance is the edge after E1, so maximum throughput is one access per 2 cycles.
- `mem_cmd`, `mem_addr` and `busy` are decoded from registered state only; they have no combinational path from request inputs.
- `mem_ready` is ignored in IDLE.

## Structure
- Shared package `fetch_mem_pkg` holds:
  - MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10
  - BR_HOLD=2'b00, BR_REL=2'b01, BR_ABS=2'b10
  - the state enum
- One sub-module, `pc_next_logic`: combinational next-PC selection (increment, relative, absolute, reset) parametrised on ADDR_W/OFF_W. The FSM and the registers stay in `fetch_mem_unit`.

## Test plan
- Reset, then `req_fetch`=1 with `mem_ready`=1 and `mem_rdata`=16'hA5C3 → `mem_cmd`=READ at addr 0 for one cycle; `instr`=16'hA5C3 with a one-cycle `instr_valid`; `pc`=1.
- Fetch with `mem_ready` low for 3 cycles → `mem_cmd`/`mem_addr` stable for 4 cycles and `busy`=1 throughout; `instr_valid` rises 5 edges after the request.
- `pc`=9'h1FF, then a fetch → `pc` wraps to 0. With `pc`=5, BR_REL with `branch_off`=8'hFE → `pc`=3. BR_ABS with `branch_tgt`=9'h040 → `pc`=9'h040.
- `req_store` and `req_fetch` together with `data_addr`=9'h012, `store_data`=16'h1234 → MEM_WRITE to 9'h012 with `mem_wdata`=16'h1234 first; the fetch is accepted only after return to IDLE.
- LOAD from 9'h0FF returning 16'hBEEF → `load_data`=16'hBEEF, `load_valid` high one cycle, `instr` and `pc` unchanged.
- reset=0 during a LOAD wait → next cycle `mem_cmd`=NONE, `busy`=0, `pc`=RESET_PC, no valid pulse.
